// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared widths, operation codes and divider states for the execute stage
package ex_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int ALU_OP_BUS   = 8;
    localparam int ALU_SEL_BUS  = 3;

    // Level of rst that resets the pipeline (active-low, sampled at posedge clk)
    localparam logic RST_ACTIVE = 1'b0;

    // aluop codes
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
    localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
    localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    // alusel result groups
    localparam logic [2:0] EXE_RES_NOP        = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
    localparam logic [2:0] EXE_RES_MUL        = 3'b101;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative radix-2 restoring divider, one quotient bit per cycle
module div
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        hold_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] divisor_q, divisor_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] quo_fix, rem_fix;

    // Next-state logic: sample magnitudes on start, then shift/subtract once per ON cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        shifted   = {rem_q, quo_q[31]};
        trial     = shifted - {1'b0, divisor_q};
        case (state_q)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = 6'd0;
                        rem_d     = 32'd0;
                        quo_d     = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
                        divisor_d = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
                        qneg_d    = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        rneg_d    = signed_div_i && opdata1_i[31];
                    end
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    // Borrow out of the trial subtraction means the divisor did not fit
                    if (!trial[32]) begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = DIV_END;
                    end
                end
            end
            DIV_BYZERO: begin
                state_d = DIV_END;
                rem_d   = 32'd0;
                quo_d   = 32'd0;
                qneg_d  = 1'b0;
                rneg_d  = 1'b0;
            end
            DIV_END: begin
                if (!hold_i) begin
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    // Divider state register; reset aborts any division in flight
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state_q   <= DIV_FREE;
            cnt_q     <= 6'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            divisor_q <= 32'd0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
        end
    end

    assign quo_fix  = qneg_q ? -quo_q : quo_q;
    assign rem_fix  = rneg_q ? -rem_q : rem_q;
    assign ready_o  = (state_q == DIV_END);
    assign result_o = ready_o ? {rem_fix, quo_fix} : 64'd0;

endmodule

// File: rtl/ex.sv
// rtl/ex.sv - MIPS execute stage: ALU, HI/LO update and divider control
module ex
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        stall_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        wb_whilo_i,
    input  logic [31:0] wb_hi_i,
    input  logic [31:0] wb_lo_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    logic [31:0]        hi_eff, lo_eff;
    logic [31:0]        logic_res, shift_res, arith_res, move_res;
    logic [31:0]        add_res, sub_res;
    logic               add_ov, sub_ov;
    logic signed [63:0] op1_sx, op2_sx;
    logic [63:0]        mul_s, mul_u;
    logic               is_div, div_ready;
    logic [63:0]        div_result;

    // Youngest in-flight HI/LO write wins over the architectural copy
    assign hi_eff = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
    assign lo_eff = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

    assign add_res = reg1_i + reg2_i;
    assign sub_res = reg1_i - reg2_i;
    assign add_ov  = (reg1_i[31] == reg2_i[31]) && (add_res[31] != reg1_i[31]);
    assign sub_ov  = (reg1_i[31] != reg2_i[31]) && (sub_res[31] != reg1_i[31]);

    assign op1_sx = {{32{reg1_i[31]}}, reg1_i};
    assign op2_sx = {{32{reg2_i[31]}}, reg2_i};
    assign mul_s  = op1_sx * op2_sx;
    assign mul_u  = {32'd0, reg1_i} * {32'd0, reg2_i};

    assign is_div = is_div_op(aluop_i);

    // Per-group results, each selected by the aluop subtype
    always_comb begin
        logic_res = 32'd0;
        shift_res = 32'd0;
        arith_res = 32'd0;
        move_res  = 32'd0;
        case (aluop_i)
            EXE_OR_OP:    logic_res = reg1_i | reg2_i;
            EXE_AND_OP:   logic_res = reg1_i & reg2_i;
            EXE_XOR_OP:   logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP:   logic_res = ~(reg1_i | reg2_i);
            EXE_SLL_OP:   shift_res = reg2_i << reg1_i[4:0];
            EXE_SRL_OP:   shift_res = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP:   shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP: arith_res = add_res;
            EXE_SUB_OP, EXE_SUBU_OP: arith_res = sub_res;
            EXE_SLT_OP:   arith_res = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
            EXE_SLTU_OP:  arith_res = {31'd0, (reg1_i < reg2_i)};
            EXE_MFHI_OP:  move_res  = hi_eff;
            EXE_MFLO_OP:  move_res  = lo_eff;
            EXE_MOVN_OP, EXE_MOVZ_OP: move_res = reg1_i;
            default: ;
        endcase
    end

    // Write-back triple, HI/LO update and stall request, all zeroed while in reset
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = 32'd0;
        whilo_o    = 1'b0;
        hi_o       = 32'd0;
        lo_o       = 32'd0;
        stallreq_o = is_div && !div_ready;

        case (alusel_i)
            EXE_RES_LOGIC:      wdata_o = logic_res;
            EXE_RES_SHIFT:      wdata_o = shift_res;
            EXE_RES_MOVE:       wdata_o = move_res;
            EXE_RES_ARITHMETIC: wdata_o = arith_res;
            EXE_RES_MUL:        wdata_o = mul_s[31:0];
            default: ;
        endcase

        if (((aluop_i == EXE_ADD_OP) || (aluop_i == EXE_ADDI_OP)) && add_ov) begin
            wreg_o = 1'b0;
        end
        if ((aluop_i == EXE_SUB_OP) && sub_ov) begin
            wreg_o = 1'b0;
        end

        case (aluop_i)
            EXE_MULT_OP: begin
                wreg_o = 1'b0;
                whilo_o = 1'b1;
                {hi_o, lo_o} = mul_s;
            end
            EXE_MULTU_OP: begin
                wreg_o = 1'b0;
                whilo_o = 1'b1;
                {hi_o, lo_o} = mul_u;
            end
            EXE_DIV_OP, EXE_DIVU_OP: begin
                wreg_o = 1'b0;
                whilo_o = div_ready;
                {hi_o, lo_o} = div_result;
            end
            EXE_MTHI_OP: begin
                wreg_o = 1'b0;
                whilo_o = 1'b1;
                hi_o = reg1_i;
                lo_o = lo_eff;
            end
            EXE_MTLO_OP: begin
                wreg_o = 1'b0;
                whilo_o = 1'b1;
                hi_o = hi_eff;
                lo_o = reg1_i;
            end
            default: ;
        endcase

        if (rst == RST_ACTIVE) begin
            wd_o       = 5'd0;
            wreg_o     = 1'b0;
            wdata_o    = 32'd0;
            whilo_o    = 1'b0;
            hi_o       = 32'd0;
            lo_o       = 32'd0;
            stallreq_o = 1'b0;
        end
    end

    div u_div (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (aluop_i == EXE_DIV_OP),
        .opdata1_i    (reg1_i),
        .opdata2_i    (reg2_i),
        .start_i      (is_div),
        .annul_i      (!is_div),
        .hold_i       (stall_i),
        .result_o     (div_result),
        .ready_o      (div_ready)
    );

endmodule

// File: tb/tb_ex.sv
// tb/tb_ex.sv - directed and randomized checks of the execute stage against a reference model
module tb_ex;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  aluop_i = 8'd0;
    logic [2:0]  alusel_i = 3'd0;
    logic [31:0] reg1_i = 32'd0, reg2_i = 32'd0;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0, stall_i = 1'b0;
    logic [31:0] hi_i = 32'd0, lo_i = 32'd0;
    logic        mem_whilo_i = 1'b0, wb_whilo_i = 1'b0;
    logic [31:0] mem_hi_i = 32'd0, mem_lo_i = 32'd0, wb_hi_i = 32'd0, wb_lo_i = 32'd0;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .stall_i(stall_i),
        .hi_i(hi_i), .lo_i(lo_i),
        .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
        .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] sel_of(input logic [7:0] op);
        case (op)
            EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP: return EXE_RES_LOGIC;
            EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:            return EXE_RES_SHIFT;
            EXE_MFHI_OP, EXE_MFLO_OP, EXE_MOVN_OP, EXE_MOVZ_OP: return EXE_RES_MOVE;
            EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP,
            EXE_SUB_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP: return EXE_RES_ARITHMETIC;
            default: return EXE_RES_NOP;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference behaviour of the non-divide operations, in plain integer arithmetic
    task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wr, input logic [31:0] he, input logic [31:0] le,
                         output logic [31:0] wd, output logic wre, output logic wh,
                         output logic [63:0] hl);
        longint s;
        logic [31:0] fill;
        wd = 32'd0; wre = wr; wh = 1'b0; hl = 64'd0;
        case (op)
            EXE_AND_OP: wd = a & b;
            EXE_OR_OP:  wd = a | b;
            EXE_XOR_OP: wd = a ^ b;
            EXE_NOR_OP: wd = ~(a | b);
            EXE_SLL_OP: wd = b << a[4:0];
            EXE_SRL_OP: wd = b >> a[4:0];
            EXE_SRA_OP: begin
                fill = 32'hFFFF_FFFF;
                fill = ~(fill >> a[4:0]);
                wd = (b >> a[4:0]) | (b[31] ? fill : 32'd0);
            end
            EXE_ADD_OP, EXE_ADDI_OP, EXE_ADDU_OP, EXE_ADDIU_OP: begin
                s = longint'($signed(a)) + longint'($signed(b));
                wd = a + b;
                if ((op == EXE_ADD_OP || op == EXE_ADDI_OP) && (s > 64'sd2147483647 || s < -64'sd2147483648))
                    wre = 1'b0;
            end
            EXE_SUB_OP, EXE_SUBU_OP: begin
                s = longint'($signed(a)) - longint'($signed(b));
                wd = a - b;
                if (op == EXE_SUB_OP && (s > 64'sd2147483647 || s < -64'sd2147483648))
                    wre = 1'b0;
            end
            EXE_SLT_OP:  wd = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            EXE_SLTU_OP: wd = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            EXE_MFHI_OP: wd = he;
            EXE_MFLO_OP: wd = le;
            EXE_MOVN_OP, EXE_MOVZ_OP: wd = a;
            EXE_MTHI_OP: begin wre = 1'b0; wh = 1'b1; hl = {a, le}; end
            EXE_MTLO_OP: begin wre = 1'b0; wh = 1'b1; hl = {he, a}; end
            EXE_MULT_OP: begin
                wre = 1'b0; wh = 1'b1;
                hl = 64'(longint'($signed(a)) * longint'($signed(b)));
            end
            EXE_MULTU_OP: begin
                wre = 1'b0; wh = 1'b1;
                hl = {32'd0, a} * {32'd0, b};
            end
            default: ;
        endcase
    endtask

    // Quotient/remainder from magnitudes, then signs applied as MIPS defines them
    task automatic div_model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r);
        logic [31:0] ma, mb;
        if (b == 32'd0) begin
            q = 32'd0; r = 32'd0;
        end else begin
            ma = (sg && a[31]) ? -a : a;
            mb = (sg && b[31]) ? -b : b;
            q = ma / mb;
            r = ma % mb;
            if (sg && (a[31] ^ b[31])) q = -q;
            if (sg && a[31]) r = -r;
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        aluop_i  = op;
        alusel_i = sel_of(op);
        reg1_i   = a;
        reg2_i   = b;
        wreg_i   = 1'b1;
        wd_i     = 5'($urandom_range(31));
    endtask

    task automatic count_stall(output int n);
        n = 0;
        @(negedge clk);
        while (stallreq_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Start a divide now, check stall length and result; leaves the bench at the END negedge
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] q, r;
        drive(op, a, b);
        div_model(op == EXE_DIV_OP, a, b, q, r);
        count_stall(n);
        chk("div_stall_cycles", 64'(n), (b == 32'd0) ? 64'd2 : 64'd33);
        chk("div_whilo", {63'd0, whilo_o}, 64'd1);
        chk("div_wreg", {63'd0, wreg_o}, 64'd0);
        chk("div_hilo", {hi_o, lo_o}, {r, q});
    endtask

    logic [7:0]  op_tab [23];
    logic [31:0] e_wd;
    logic        e_wre, e_wh;
    logic [63:0] e_hl;
    logic [31:0] he, le;
    logic [7:0]  op;
    int          pulses, n;

    initial begin
        op_tab = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
                   EXE_SRA_OP, EXE_ADD_OP, EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP, EXE_ADDI_OP,
                   EXE_ADDIU_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_MFHI_OP, EXE_MFLO_OP, EXE_MOVN_OP,
                   EXE_MOVZ_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_MULT_OP, EXE_MULTU_OP};

        // reset: every output is zero, even with a live divide and a write request present
        drive(EXE_DIV_OP, 32'd100, 32'd7);
        wd_i = 5'd9;
        repeat (2) @(negedge clk);
        chk("rst_wd", {59'd0, wd_o}, 64'd0);
        chk("rst_wreg", {63'd0, wreg_o}, 64'd0);
        chk("rst_wdata", {32'd0, wdata_o}, 64'd0);
        chk("rst_whilo", {63'd0, whilo_o}, 64'd0);
        chk("rst_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_lo", {32'd0, lo_o}, 64'd0);
        chk("rst_stallreq", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(EXE_NOP_OP, 32'd0, 32'd0);

        // directed combinational cases
        @(posedge clk); #1; drive(EXE_ADD_OP, 32'h7FFF_FFFF, 32'd1);
        @(negedge clk); chk("add_ovf_wreg", {63'd0, wreg_o}, 64'd0);
        @(posedge clk); #1; drive(EXE_ADDU_OP, 32'h7FFF_FFFF, 32'd1);
        @(negedge clk); chk("addu_wreg", {63'd0, wreg_o}, 64'd1);
        chk("addu_wdata", {32'd0, wdata_o}, 64'h8000_0000);
        chk("addu_wd", {59'd0, wd_o}, {59'd0, wd_i});
        @(posedge clk); #1; drive(EXE_SRA_OP, 32'd4, 32'hF000_0000);
        @(negedge clk); chk("sra", {32'd0, wdata_o}, 64'hFF00_0000);
        @(posedge clk); #1; drive(EXE_SLTU_OP, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk); chk("sltu", {32'd0, wdata_o}, 64'd0);
        @(posedge clk); #1; drive(EXE_SLT_OP, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk); chk("slt", {32'd0, wdata_o}, 64'd1);
        @(posedge clk); #1; drive(EXE_MFHI_OP, 32'd0, 32'd0);
        hi_i = 32'd1; wb_whilo_i = 1'b1; wb_hi_i = 32'd2; mem_whilo_i = 1'b1; mem_hi_i = 32'd3;
        @(negedge clk); chk("mfhi_mem_fwd", {32'd0, wdata_o}, 64'd3);
        @(posedge clk); #1; mem_whilo_i = 1'b0;
        @(negedge clk); chk("mfhi_wb_fwd", {32'd0, wdata_o}, 64'd2);
        @(posedge clk); #1; wb_whilo_i = 1'b0;
        @(negedge clk); chk("mfhi_arch", {32'd0, wdata_o}, 64'd1);
        @(posedge clk); #1; drive(EXE_MULT_OP, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk);
        chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mult_whilo", {63'd0, whilo_o}, 64'd1);
        chk("mult_wreg", {63'd0, wreg_o}, 64'd0);

        // randomized combinational operations against the model
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            op = op_tab[$urandom_range(22)];
            drive(op, pick(), pick());
            wreg_i = 1'($urandom_range(1));
            hi_i = $urandom; lo_i = $urandom;
            mem_whilo_i = 1'($urandom_range(1)); mem_hi_i = $urandom; mem_lo_i = $urandom;
            wb_whilo_i = 1'($urandom_range(1)); wb_hi_i = $urandom; wb_lo_i = $urandom;
            he = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
            le = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);
            model(op, reg1_i, reg2_i, wreg_i, he, le, e_wd, e_wre, e_wh, e_hl);
            @(negedge clk);
            chk("rnd_wd", {59'd0, wd_o}, {59'd0, wd_i});
            chk("rnd_wreg", {63'd0, wreg_o}, {63'd0, e_wre});
            chk("rnd_whilo", {63'd0, whilo_o}, {63'd0, e_wh});
            chk("rnd_stallreq", {63'd0, stallreq_o}, 64'd0);
            if (e_wre) chk("rnd_wdata", {32'd0, wdata_o}, {32'd0, e_wd});
            if (e_wh)  chk("rnd_hilo", {hi_o, lo_o}, e_hl);
        end

        // divide -7/2, held in END by the pipeline for three cycles
        @(posedge clk); #1;
        run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_whilo", {63'd0, whilo_o}, 64'd1);
            chk("hold_stallreq", {63'd0, stallreq_o}, 64'd0);
            chk("hold_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        end
        stall_i = 1'b0;

        // divide by zero, directly after the previous one
        @(posedge clk); #1;
        run_div(EXE_DIVU_OP, 32'd100, 32'd0);

        // back-to-back random divides
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            run_div(($urandom_range(1) == 1) ? EXE_DIV_OP : EXE_DIVU_OP, pick(),
                    ($urandom_range(4) == 0) ? 32'd0 : pick());
        end

        // reset during iteration 10 aborts the divide
        @(posedge clk); #1;
        drive(EXE_DIV_OP, 32'd12345, 32'd17);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_stallreq", {63'd0, stallreq_o}, 64'd0);
        chk("midrst_whilo", {63'd0, whilo_o}, 64'd0);
        rst = 1'b1;
        drive(EXE_NOP_OP, 32'd0, 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) pulses++;
        end
        chk("postrst_no_pulse", 64'(pulses), 64'd0);
        @(posedge clk); #1;
        run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        drive(EXE_NOP_OP, 32'd0, 32'd0);
        @(negedge clk);
        chk("after_div_stallreq", {63'd0, stallreq_o}, 64'd0);

        // annulled divide: leaving the op mid-division drops back to FREE
        @(posedge clk); #1;
        drive(EXE_DIVU_OP, 32'd50, 32'd3);
        repeat (5) @(negedge clk);
        drive(EXE_NOP_OP, 32'd0, 32'd0);
        @(posedge clk); #1;
        run_div(EXE_DIVU_OP, 32'd50, 32'd3);
        n = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
